// File: rtl/ei_reg_bank.sv
// rtl/ei_reg_bank.sv - BLE setup register bank with shadowed timer commit and sticky errors.
// Optional write lock on setup registers: define EI_REG_LOCK_EN.
module ei_reg_bank #(
   parameter int                DATA_W   = 8,
   parameter int                NUM_REGS = 47,
   parameter int                ADDR_W   = 6,
   parameter logic [DATA_W-1:0] BAUD_RST = 8'h04
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         rd_req,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic                         rd_valid,
   output logic [DATA_W-1:0]            rd_data,
   input  logic                         rx_wr,
   input  logic [DATA_W-1:0]            rx_byte,
   input  logic [DATA_W-1:0]            err_set,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic [5:0]                   tmr_update,
   output logic                         tx_wr
);

   localparam int NGRP   = 6;
   localparam int I_PROG = 5;
   localparam int I_BAUD = 30;
   localparam int I_RX   = 43;
   localparam int I_TX   = 44;
   localparam int I_ERR  = 46;

   localparam logic [ADDR_W-1:0] A_PROG = ADDR_W'(I_PROG);
   localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(I_RX);
   localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(I_TX);
   localparam logic [ADDR_W-1:0] A_ERR  = ADDR_W'(I_ERR);
   localparam logic [ADDR_W:0]   NREG   = (ADDR_W+1)'(NUM_REGS);

   // TMR0 address of each timer group: SLP, ADV, CONN, OPDS, DELAY, ACK
   localparam logic [ADDR_W-1:0] TMR_BASE [NGRP] = '{
      ADDR_W'(2), ADDR_W'(7), ADDR_W'(31), ADDR_W'(34), ADDR_W'(37), ADDR_W'(40)
   };

   typedef enum logic {S_IDLE, S_COMMIT} state_t;

   state_t            state;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] sh0  [NGRP];
   logic [DATA_W-1:0] sh1  [NGRP];
   logic [DATA_W-1:0] sh2;
   logic [2:0]        cgrp;

   logic              wr_fire;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              wr_ro;
   logic              wr_locked;
   logic              wr_ok;
   logic [DATA_W-1:0] err_int;
   logic [DATA_W-1:0] err_clr;
   logic              t_hit;
   logic [2:0]        t_grp;
   logic [1:0]        t_pos;
   logic [ADDR_W-1:0] t_off;

   assign wr_fire     = wr_valid && wr_ready;
   assign wr_in_range = {1'b0, wr_addr} < NREG;
   assign rd_in_range = {1'b0, rd_addr} < NREG;
   assign wr_ro       = (wr_addr == A_RX);

`ifdef EI_REG_LOCK_EN
   assign wr_locked = (wr_addr != '0) && (wr_addr <= ADDR_W'(42)) && (wr_addr != A_PROG)
                      && (regs[I_PROG] != DATA_W'(8'hA5));
`else
   assign wr_locked = 1'b0;
`endif

   assign wr_ok   = wr_fire && wr_in_range && !wr_ro && !wr_locked;
   assign err_clr = (wr_ok && wr_addr == A_ERR) ? wr_data : '0;

   always_comb begin
      err_int    = '0;
      err_int[0] = wr_fire && wr_ro;
      err_int[1] = (wr_fire && !wr_in_range) || (rd_req && !rd_in_range);
`ifdef EI_REG_LOCK_EN
      err_int[3] = wr_fire && wr_in_range && wr_locked;
`endif
   end

   // Offset wraps to a large value below the base, so one compare per group suffices
   always_comb begin
      t_hit = 1'b0;
      t_grp = '0;
      t_pos = '0;
      t_off = '0;
      for (int g = 0; g < NGRP; g++) begin
         t_off = wr_addr - TMR_BASE[g];
         if (t_off < ADDR_W'(3)) begin
            t_hit = 1'b1;
            t_grp = 3'(g);
            t_pos = t_off[1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REGS; k++)
            regs[k] <= (k == I_BAUD) ? BAUD_RST : '0;
         for (int g = 0; g < NGRP; g++) begin
            sh0[g] <= '0;
            sh1[g] <= '0;
         end
         sh2        <= '0;
         cgrp       <= '0;
         state      <= S_IDLE;
         wr_ready   <= 1'b1;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         tmr_update <= '0;
         tx_wr      <= 1'b0;
      end else begin
         rd_valid   <= rd_req;
         tx_wr      <= 1'b0;
         tmr_update <= '0;

         if (rd_req)
            rd_data <= rd_in_range ? regs[rd_addr] : '0;

         if (rx_wr)
            regs[I_RX] <= rx_byte;

         regs[I_ERR] <= (regs[I_ERR] & ~err_clr) | err_set | err_int;

         case (state)
            S_IDLE: begin
               if (wr_ok) begin
                  if (t_hit) begin
                     case (t_pos)
                        2'd0:    sh0[t_grp] <= wr_data;
                        2'd1:    sh1[t_grp] <= wr_data;
                        default: begin
                           sh2        <= wr_data;
                           cgrp       <= t_grp;
                           state      <= S_COMMIT;
                           wr_ready   <= 1'b0;
                           tmr_update <= 6'b1 << t_grp;
                        end
                     endcase
                  end else if (wr_addr != A_ERR) begin
                     regs[wr_addr] <= wr_data;
                  end
                  if (wr_addr == A_TX)
                     tx_wr <= 1'b1;
               end
            end
            S_COMMIT: begin
               regs[TMR_BASE[cgrp]]                <= sh0[cgrp];
               regs[TMR_BASE[cgrp] + ADDR_W'(1)]   <= sh1[cgrp];
               regs[TMR_BASE[cgrp] + ADDR_W'(2)]   <= sh2;
               state    <= S_IDLE;
               wr_ready <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               wr_ready <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      regs_o = '0;
      for (int k = 0; k < NUM_REGS; k++)
         regs_o[k*DATA_W +: DATA_W] = regs[k];
   end

endmodule

// File: tb/tb_ei_reg_bank.sv
// tb/tb_ei_reg_bank.sv - directed table-driven bench for ei_reg_bank.
module tb_ei_reg_bank;

   localparam int DW = 8;
   localparam int NR = 47;
   localparam int AW = 6;

   localparam int OP_WR  = 0;
   localparam int OP_RD  = 1;
   localparam int OP_REG = 2;
   localparam int OP_NOP = 3;

   typedef struct {
      int         op;
      int         addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_valid;
   logic             wr_ready;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             rd_req;
   logic [AW-1:0]    rd_addr;
   logic             rd_valid;
   logic [DW-1:0]    rd_data;
   logic             rx_wr;
   logic [DW-1:0]    rx_byte;
   logic [DW-1:0]    err_set;
   logic [NR*DW-1:0] regs_o;
   logic [5:0]       tmr_update;
   logic             tx_wr;

   int               checks   = 0;
   int               failures = 0;
   logic [5:0]       upd_log  = '0;
   vec_t             tbl[$];

   ei_reg_bank dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .rx_wr(rx_wr), .rx_byte(rx_byte), .err_set(err_set),
      .regs_o(regs_o), .tmr_update(tmr_update), .tx_wr(tx_wr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) upd_log <= upd_log | tmr_update;

   function automatic logic [7:0] reg_at(input int k);
      return regs_o[k*DW +: DW];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // All tasks start and end on a falling edge
   task automatic do_wr(input int a, input logic [7:0] d);
      int n;
      wr_valid = 1'b1;
      wr_addr  = AW'(a);
      wr_data  = d;
      n = 0;
      while (!wr_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) begin
         checks++;
         failures++;
         $display("FAIL wr_ready_timeout addr=%0d actual=0 expected=1", a);
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic do_rd(input string nm, input int a, input logic [7:0] exp);
      rd_req  = 1'b1;
      rd_addr = AW'(a);
      @(negedge clk);
      rd_req = 1'b0;
      chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
      chk({nm, "_data"}, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0; rx_wr = 1'b0; rx_byte = '0; err_set = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < NR; k++)
         chk($sformatf("rst_reg%0d", k), 32'(reg_at(k)), (k == 30) ? 32'h04 : 32'h00);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_tmr_update", 32'(tmr_update), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_tx_wr", 32'(tx_wr), 32'd0);

      // ADV group: shadow writes, then TMR2 commit
      upd_log = '0;
      do_wr(7, 8'h11);
      do_wr(8, 8'h22);
      chk("adv_shadow7", 32'(reg_at(7)), 32'h00);
      do_rd("adv_rd8_pre", 8, 8'h00);
      do_wr(9, 8'h33);
      chk("adv_commit_ready", 32'(wr_ready), 32'd0);
      chk("adv_commit_upd", 32'(tmr_update), 32'b000010);
      @(negedge clk);
      chk("adv_post_ready", 32'(wr_ready), 32'd1);
      chk("adv_post_upd", 32'(tmr_update), 32'd0);
      chk("adv_upd_log", 32'(upd_log), 32'b000010);
      do_rd("adv_rd7", 7, 8'h11);
      do_rd("adv_rd8", 8, 8'h22);
      do_rd("adv_rd9", 9, 8'h33);

      tbl.push_back('{OP_WR,  43, 8'hFF, 8'h00});
      tbl.push_back('{OP_REG, 43, 8'h00, 8'h00});
      tbl.push_back('{OP_REG, 46, 8'h00, 8'h01});
      tbl.push_back('{OP_WR,  46, 8'h01, 8'h00});
      tbl.push_back('{OP_REG, 46, 8'h00, 8'h00});
      tbl.push_back('{OP_RD,  30, 8'h00, 8'h04});
      tbl.push_back('{OP_WR,  12, 8'h9C, 8'h00});
      tbl.push_back('{OP_RD,  12, 8'h00, 8'h9C});
      tbl.push_back('{OP_REG, 12, 8'h00, 8'h9C});
      tbl.push_back('{OP_WR,   2, 8'h77, 8'h00});
      tbl.push_back('{OP_REG,  2, 8'h00, 8'h00});
      tbl.push_back('{OP_RD,   2, 8'h00, 8'h00});
      tbl.push_back('{OP_WR,   3, 8'h88, 8'h00});
      tbl.push_back('{OP_WR,   4, 8'h99, 8'h00});
      tbl.push_back('{OP_NOP,  0, 8'h00, 8'h00});
      tbl.push_back('{OP_REG,  2, 8'h00, 8'h77});
      tbl.push_back('{OP_REG,  3, 8'h00, 8'h88});
      tbl.push_back('{OP_RD,   4, 8'h00, 8'h99});
      tbl.push_back('{OP_REG, 46, 8'h00, 8'h00});

      for (int i = 0; i < tbl.size(); i++) begin
         case (tbl[i].op)
            OP_WR:  do_wr(tbl[i].addr, tbl[i].data);
            OP_RD:  do_rd($sformatf("tbl%0d_rd%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
            OP_REG: chk($sformatf("tbl%0d_reg%0d", i, tbl[i].addr),
                        32'(reg_at(tbl[i].addr)), 32'(tbl[i].exp));
            default: @(negedge clk);
         endcase
      end

      // TX strobe follows the accepting edge by one cycle
      do_wr(44, 8'h3C);
      chk("tx_pulse", 32'(tx_wr), 32'd1);
      @(negedge clk);
      chk("tx_pulse_end", 32'(tx_wr), 32'd0);
      do_rd("tx_rd", 44, 8'h3C);

      rx_wr = 1'b1; rx_byte = 8'h5A;
      @(negedge clk);
      rx_wr = 1'b0;
      do_rd("rx_rd43", 43, 8'h5A);

      // Out-of-range read, concurrent err_set and W1C of the same bit
      rd_req = 1'b1; rd_addr = AW'(50);
      err_set = 8'h02;
      wr_valid = 1'b1; wr_addr = AW'(46); wr_data = 8'h02;
      @(negedge clk);
      rd_req = 1'b0; err_set = '0; wr_valid = 1'b0;
      chk("oor_rd_valid", 32'(rd_valid), 32'd1);
      chk("oor_rd_data", 32'(rd_data), 32'h00);
      chk("oor_err_sticky", 32'(reg_at(46)), 32'h02);
      do_wr(46, 8'h02);
      chk("err_clr1", 32'(reg_at(46)), 32'h00);
      do_wr(60, 8'hEE);
      chk("oor_wr_err", 32'(reg_at(46)), 32'h02);
      do_wr(46, 8'h02);

      // Same-cycle read and write of one address returns the old value
      rd_req = 1'b1; rd_addr = AW'(12);
      wr_valid = 1'b1; wr_addr = AW'(12); wr_data = 8'h55;
      @(negedge clk);
      rd_req = 1'b0; wr_valid = 1'b0;
      chk("rw_old", 32'(rd_data), 32'h9C);
      @(negedge clk);
      chk("rd_valid_drop", 32'(rd_valid), 32'd0);
      chk("rd_data_hold", 32'(rd_data), 32'h9C);
      do_rd("rw_new", 12, 8'h55);

      // Reset landing in the ACK commit cycle
      do_wr(40, 8'hAA);
      do_wr(41, 8'hBB);
      upd_log = '0;
      wr_valid = 1'b1; wr_addr = AW'(42); wr_data = 8'hCC;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_upd_log", 32'(upd_log), 32'd0);
      chk("abort_reg40", 32'(reg_at(40)), 32'h00);
      chk("abort_reg41", 32'(reg_at(41)), 32'h00);
      chk("abort_reg42", 32'(reg_at(42)), 32'h00);
      chk("abort_reg30", 32'(reg_at(30)), 32'h04);
      chk("abort_ready", 32'(wr_ready), 32'd1);

`ifdef EI_REG_LOCK_EN
      do_wr(30, 8'h07);
      chk("lock_reg30", 32'(reg_at(30)), 32'h04);
      chk("lock_err", 32'(reg_at(46)), 32'h08);
      do_wr(46, 8'h08);
      do_wr(5, 8'hA5);
      do_wr(30, 8'h07);
      chk("unlock_reg30", 32'(reg_at(30)), 32'h07);
      chk("unlock_err", 32'(reg_at(46)), 32'h00);
`else
      do_wr(30, 8'h07);
      chk("nolock_reg30", 32'(reg_at(30)), 32'h07);
      chk("nolock_err", 32'(reg_at(46)), 32'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
